gb_processor: RTL and testbench

Execution core of the Game Boy (LR35902-style) CPU subset: an 8-bit register file (A, B, C, D, E, F, H, L) and the ALU for the register-operand arithmetic/logic opcode group 0x80–0xBF. It sits behind the instruction fetch/decode front end, which delivers one opcode per cycle with a `valid` qualifier. The full architectural register state is exported on `probe` for verification. The bench connects through the `gbprocessor_iface` interface.

---
 rtl/gb_processor.sv | 148 ++++++++++++++
 tb/tb_gb_processor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/gb_processor.sv
// gb_processor: LR35902-style register file plus the ALU for the
// register-operand opcode group 0x80-0xBF. A and F are the only registers
// written by instructions; B, C, D, E, H and L hold their reset values.
module gb_processor (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  instruction,
  input  logic        valid,
  output logic [63:0] probe
);

  localparam logic [7:0] A_RST = 8'h01;
  localparam logic [7:0] B_RST = 8'h02;
  localparam logic [7:0] C_RST = 8'h03;
  localparam logic [7:0] D_RST = 8'h04;
  localparam logic [7:0] E_RST = 8'h05;
  localparam logic [7:0] F_RST = 8'h00;
  localparam logic [7:0] H_RST = 8'h06;
  localparam logic [7:0] L_RST = 8'h07;

  logic [7:0] a_r, b_r, c_r, d_r, e_r, f_r, h_r, l_r;
  logic [7:0] src_s;
  logic [7:0] a_next_s;
  logic [7:0] f_next_s;
  logic       exec_s;

  // ALU for one opcode: returns {new A, new F}. The carry-in from F only
  // participates for ADC and SBC; CP computes like SUB but keeps A.
  function automatic logic [15:0] alu_result(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] s,
    input logic       carry_flag
  );
    logic       cin;
    logic [8:0] wide_add;
    logic [4:0] half_add;
    logic [8:0] wide_sub;
    logic [4:0] half_sub;
    logic [7:0] res;
    logic [7:0] a_out;
    logic       n_flag;
    logic       h_flag;
    logic       c_flag;
    cin      = ((op == 3'd1) || (op == 3'd3)) ? carry_flag : 1'b0;
    wide_add = {1'b0, a} + {1'b0, s} + {8'd0, cin};
    half_add = {1'b0, a[3:0]} + {1'b0, s[3:0]} + {4'd0, cin};
    // A 9-bit difference goes negative (bit 8 set) exactly when a borrow occurs.
    wide_sub = {1'b0, a} - {1'b0, s} - {8'd0, cin};
    half_sub = {1'b0, a[3:0]} - {1'b0, s[3:0]} - {4'd0, cin};
    res      = a;
    a_out    = a;
    n_flag   = 1'b0;
    h_flag   = 1'b0;
    c_flag   = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        res    = wide_add[7:0];
        a_out  = res;
        h_flag = half_add[4];
        c_flag = wide_add[8];
      end
      3'd2, 3'd3: begin
        res    = wide_sub[7:0];
        a_out  = res;
        n_flag = 1'b1;
        h_flag = half_sub[4];
        c_flag = wide_sub[8];
      end
      3'd4: begin
        res    = a & s;
        a_out  = res;
        h_flag = 1'b1;
      end
      3'd5: begin
        res   = a ^ s;
        a_out = res;
      end
      3'd6: begin
        res   = a | s;
        a_out = res;
      end
      3'd7: begin
        res    = wide_sub[7:0];
        a_out  = a;
        n_flag = 1'b1;
        h_flag = half_sub[4];
        c_flag = wide_sub[8];
      end
      default: begin
        res   = a;
        a_out = a;
      end
    endcase
    return {a_out, (res == 8'd0), n_flag, h_flag, c_flag, 4'b0000};
  endfunction

  // Decode the source operand and compute the next A/F for this cycle.
  always_comb begin
    a_next_s = a_r;
    f_next_s = f_r;
    src_s    = 8'd0;
    case (instruction[2:0])
      3'd0:    src_s = b_r;
      3'd1:    src_s = c_r;
      3'd2:    src_s = d_r;
      3'd3:    src_s = e_r;
      3'd4:    src_s = h_r;
      3'd5:    src_s = l_r;
      3'd7:    src_s = a_r;
      default: src_s = 8'd0;
    endcase
    // (HL) operands need memory, which this core lacks, so they are no-ops.
    exec_s = valid && (instruction[7:6] == 2'b10) && (instruction[2:0] != 3'd6);
    if (exec_s) begin
      {a_next_s, f_next_s} = alu_result(instruction[5:3], a_r, src_s, f_r[4]);
    end else begin
      a_next_s = a_r;
      f_next_s = f_r;
    end
  end

  // Architectural register update; reset wins over any presented instruction.
  always_ff @(posedge clock) begin
    if (!reset) begin
      a_r <= A_RST;
      b_r <= B_RST;
      c_r <= C_RST;
      d_r <= D_RST;
      e_r <= E_RST;
      f_r <= F_RST;
      h_r <= H_RST;
      l_r <= L_RST;
    end else begin
      a_r <= a_next_s;
      f_r <= f_next_s;
      b_r <= b_r;
      c_r <= c_r;
      d_r <= d_r;
      e_r <= e_r;
      h_r <= h_r;
      l_r <= l_r;
    end
  end

  assign probe = {a_r, b_r, c_r, d_r, e_r, f_r, h_r, l_r};

endmodule

// File: tb/tb_gb_processor.sv
// Self-checking bench for gb_processor: directed steps plus randomized
// stimulus compared against an arithmetic reference model of the ALU rules.
module tb_gb_processor;

  logic        clock;
  logic        reset;
  logic [7:0]  instruction;
  logic        valid;
  logic [63:0] probe;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: only A and F ever change.
  int ma;
  int mf;

  gb_processor dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .valid       (valid),
    .probe       (probe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] model_probe();
    logic [7:0] a8;
    logic [7:0] f8;
    a8 = ma[7:0];
    f8 = mf[7:0];
    return {a8, 8'h02, 8'h03, 8'h04, 8'h05, f8, 8'h06, 8'h07};
  endfunction

  function automatic int reg_val(input int idx);
    case (idx)
      0: return 2;
      1: return 3;
      2: return 4;
      3: return 5;
      4: return 6;
      5: return 7;
      7: return ma;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    ma = 1;
    mf = 0;
  endtask

  task automatic model_exec(input logic [7:0] ins);
    int op, s, cin, r, z, n, h, c, res;
    if (ins[7:6] != 2'b10 || ins[2:0] == 3'd6) return;
    op  = int'(ins[5:3]);
    s   = reg_val(int'(ins[2:0]));
    cin = (op == 1 || op == 3) ? ((mf / 16) % 2) : 0;
    n = 0; h = 0; c = 0; res = ma;
    case (op)
      0, 1: begin
        r = ma + s + cin;
        res = r % 256;
        h = ((ma % 16) + (s % 16) + cin > 15) ? 1 : 0;
        c = (r > 255) ? 1 : 0;
      end
      2, 3, 7: begin
        r = ma - s - cin;
        res = (r + 256) % 256;
        n = 1;
        h = ((ma % 16) < (s % 16) + cin) ? 1 : 0;
        c = (ma < s + cin) ? 1 : 0;
      end
      4: begin res = ma & s; h = 1; end
      5: res = ma ^ s;
      6: res = ma | s;
      default: res = ma;
    endcase
    z  = (res == 0) ? 1 : 0;
    mf = z * 128 + n * 64 + h * 32 + c * 16;
    if (op != 7) ma = res;
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge: drive inputs, advance the model, sample #1 after the edge.
  task automatic step(input logic [7:0] ins, input logic v, input logic rst_n, input string tag);
    instruction = ins;
    valid       = v;
    reset       = rst_n;
    @(posedge clock);
    if (!rst_n) model_reset();
    else if (v) model_exec(ins);
    #1;
    check64(tag, probe, model_probe());
  endtask

  task automatic expect_af(input string tag, input logic [7:0] a, input logic [7:0] f);
    check8({tag, "_A"}, probe[63:56], a);
    check8({tag, "_F"}, probe[23:16], f);
  endtask

  initial begin
    logic [7:0] op8;
    model_reset();
    instruction = 8'h00;
    valid       = 1'b0;
    reset       = 1'b0;

    // Reset hold, then idle.
    for (int i = 0; i < 5; i++) begin
      step(8'h80, 1'b1, 1'b0, "reset_hold");
      check64("reset_const", probe, 64'h0102_0304_0500_0607);
    end
    for (int i = 0; i < 5; i++) begin
      step(8'h80, 1'b0, 1'b1, "idle");
      check64("idle_const", probe, 64'h0102_0304_0500_0607);
    end

    // ADD / ADC / SUB A,A.
    step(8'h80, 1'b1, 1'b1, "add_ab");   expect_af("add_ab", 8'h03, 8'h00);
    step(8'h8C, 1'b1, 1'b1, "adc_ah");   expect_af("adc_ah", 8'h09, 8'h00);
    step(8'h97, 1'b1, 1'b1, "sub_aa");   expect_af("sub_aa", 8'h00, 8'hC0);

    // Borrow chain.
    step(8'h00, 1'b0, 1'b0, "rst1");
    step(8'h90, 1'b1, 1'b1, "sub_ab");   expect_af("sub_ab", 8'hFF, 8'h70);
    step(8'h99, 1'b1, 1'b1, "sbc_ac");   expect_af("sbc_ac", 8'hFB, 8'h40);

    // Logic and compare.
    step(8'h00, 1'b0, 1'b0, "rst2");
    step(8'hA5, 1'b1, 1'b1, "and_al");   expect_af("and_al", 8'h01, 8'h20);
    step(8'hAF, 1'b1, 1'b1, "xor_aa");   expect_af("xor_aa", 8'h00, 8'h80);
    step(8'h00, 1'b0, 1'b0, "rst3");
    step(8'hB8, 1'b1, 1'b1, "cp_ab");    expect_af("cp_ab", 8'h01, 8'h70);

    // Ignored inputs leave probe unchanged (A=01, F=70 from CP).
    step(8'h8C, 1'b0, 1'b1, "ign_nv");   expect_af("ign_nv", 8'h01, 8'h70);
    step(8'h00, 1'b1, 1'b1, "ign_00");   expect_af("ign_00", 8'h01, 8'h70);
    step(8'h86, 1'b1, 1'b1, "ign_86");   expect_af("ign_86", 8'h01, 8'h70);
    step(8'hC6, 1'b1, 1'b1, "ign_c6");   expect_af("ign_c6", 8'h01, 8'h70);

    // Opcode sweep from 0x8D with 8-bit wrap.
    step(8'h00, 1'b0, 1'b0, "rst4");
    op8 = 8'h8D;
    for (int i = 0; i < 255; i++) begin
      step(op8, 1'b1, 1'b1, "sweep");
      op8 = op8 + 8'd1;
    end
    // Reset priority over a valid instruction.
    step(8'h80, 1'b1, 1'b0, "rst_prio");
    check64("rst_prio_const", probe, 64'h0102_0304_0500_0607);

    // Randomized opcodes, valid and occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r_ins;
      logic       r_v;
      logic       r_rst;
      r_ins = 8'($urandom_range(255, 0));
      if ($urandom_range(3, 0) != 0) r_ins[7:6] = 2'b10;
      r_v   = ($urandom_range(7, 0) != 0);
      r_rst = ($urandom_range(31, 0) != 0);
      step(r_ins, r_v, r_rst, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
